fetch: RTL

Instruction-fetch stage of the five-stage MIPS pipeline; sits directly upstream of decode. Holds the PC and drives a req/ready instruction-memory port. Owns the IF/ID pipeline register that feeds decode with `pc+4` and the instruction word. Applies branch/jump redirects from decode with one architectural delay slot, and honours hazard-unit stalls.

---
 rtl/fetch.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch -- instruction-fetch stage of the five-stage MIPS pipeline.
//
// Holds the PC, drives a req/ready instruction-memory port, and owns the IF/ID
// register that feeds decode with {pc+4, instruction}. Branch/jump redirects
// from decode take effect after one architectural delay slot. Hazard stalls
// freeze the PC and IF/ID.
//
// Ports
//   i_clk, i_nrst        clock, asynchronous active-low reset
//   i_con_stall          hazard stall: PC/IF-ID hold, redirect inputs ignored
//   i_con_ifbranch       branch taken (target i_addr_pcadd)
//   i_con_jump           00 none, 01 absolute (i_addr_jump), 10 register
//                        (i_data_jr), 11 none
//   i_addr_pcadd         branch target
//   i_addr_jump          j/jal target
//   i_data_jr            jr/jalr target
//   o_imem_req           fetch request
//   o_imem_addr          fetch address (= PC register)
//   i_imem_ready         memory has data for the current request
//   i_imem_rdata         instruction word, valid with i_imem_ready
//   o_addr_pc4           IF/ID pc+4
//   o_data_instr         IF/ID instruction; 32'h0 is a bubble (sll nop)
//   o_addr_pc            current PC (debug)
// -----------------------------------------------------------------------------
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_con_stall,
  input  logic        i_con_ifbranch,
  input  logic [1:0]  i_con_jump,
  input  logic [31:0] i_addr_pcadd,
  input  logic [31:0] i_addr_jump,
  input  logic [31:0] i_data_jr,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_addr_pc4,
  output logic [31:0] o_data_instr,
  output logic [31:0] o_addr_pc
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_p1, pc4_d;
  logic [31:0] instr_p1, instr_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] hold_buf_q, hold_buf_d;

  logic        jump_abs;
  logic        jump_reg;
  logic        redirect_now;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        pc_adv;

  // Redirect qualification: a jump always beats a branch; 11 behaves as none.
  always_comb begin
    jump_abs     = (i_con_jump == 2'b01);
    jump_reg     = (i_con_jump == 2'b10);
    redirect_now = !i_con_stall && (jump_abs || jump_reg || i_con_ifbranch);
    if (jump_abs) begin
      redirect_tgt = i_addr_jump;
    end else if (jump_reg) begin
      redirect_tgt = i_data_jr;
    end else begin
      redirect_tgt = i_addr_pcadd;
    end
    pc_plus4 = pc_q + 32'd4;
    // A live redirect wins over a remembered one; the remembered one exists
    // only because bubbles delayed the delay slot.
    if (redirect_now) begin
      next_pc = redirect_tgt;
    end else if (pend_vld_q) begin
      next_pc = pend_tgt_q;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc4_d      = pc4_p1;
    instr_d    = instr_p1;
    hold_buf_d = hold_buf_q;
    pc_adv     = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_imem_ready && !i_con_stall) begin
          pc4_d   = pc_plus4;
          instr_d = i_imem_rdata;
          pc_adv  = 1'b1;
        end else if (i_imem_ready) begin
          // Word arrived during a stall: park it so memory is not re-asked.
          hold_buf_d = i_imem_rdata;
          state_d    = ST_HOLD;
        end else if (!i_con_stall) begin
          instr_d = 32'h0;
        end
      end
      ST_HOLD: begin
        if (!i_con_stall) begin
          pc4_d   = pc_plus4;
          instr_d = hold_buf_q;
          pc_adv  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    pd_default: begin
      pc_d       = pc_q;
      pend_vld_d = pend_vld_q;
      pend_tgt_d = pend_tgt_q;
    end
    if (pc_adv) begin
      pc_d       = next_pc;
      pend_vld_d = 1'b0;
    end else if (redirect_now && !pend_vld_q) begin
      // The first redirect seen while the PC is frozen is the one decode
      // acted on; later ones come from bubbles or repeated presentation.
      pend_vld_d = 1'b1;
      pend_tgt_d = redirect_tgt;
    end
  end

  // ---- IF/ID boundary (stage p1) and fetch control registers ----
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pc4_p1     <= 32'h0;
      instr_p1   <= 32'h0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'h0;
      hold_buf_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc4_p1     <= pc4_d;
      instr_p1   <= instr_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      hold_buf_q <= hold_buf_d;
    end
  end

  // Request decodes from the state register alone, so reset drops it at once.
  assign o_imem_req   = (state_q == ST_FETCH);
  assign o_imem_addr  = pc_q;
  assign o_addr_pc    = pc_q;
  assign o_addr_pc4   = pc4_p1;
  assign o_data_instr = instr_p1;

endmodule
